rv32i_test_ctrl: RTL and testbench

Synthesizable test-sequencing and completion monitor for riscv-tests style runs on one or more rv32i harts. On start it pulses the core reset for a programmable length, then watches every hart for its first ecall. It samples gp (x3) at that ecall and classifies the hart as pass, fail (with decoded test number) or timeout. It generalises the simulation-only pass/fail poller to N harts, configurable reset/timeout/pass value, abort and re-run, and registered status for FPGA or emulation use.

---
 rtl/rv32i_test_ctrl.sv | 113 +++++++++++
 tb/tb_rv32i_test_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_test_ctrl.sv
// rv32i_test_ctrl: sequences core reset and classifies each hart's first ecall as pass, fail or timeout.
module rv32i_test_ctrl #(
  parameter int NUM_HARTS = 1,
  parameter int XLEN = 32,
  parameter int RST_CYCLES = 10,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter logic [XLEN-1:0] PASS_VALUE = 1,
  parameter int CNT_W = $clog2(TIMEOUT_CYCLES + 1),
  parameter int FH_W = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [NUM_HARTS-1:0]      is_ecall,
  input  logic [NUM_HARTS*XLEN-1:0] gp_value,
  output logic                      core_rst_n,
  output logic                      busy,
  output logic                      done,
  output logic                      done_pulse,
  output logic                      pass,
  output logic                      timeout,
  output logic [NUM_HARTS-1:0]      hart_done,
  output logic [NUM_HARTS-1:0]      hart_pass,
  output logic [FH_W-1:0]           fail_hart,
  output logic [XLEN-2:0]           fail_testnum,
  output logic [CNT_W-1:0]          run_cycles
);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam logic [1:0] IDLE = 2'd0, RESET = 2'd1, RUN = 2'd2, DONE = 2'd3;
  logic [1:0] state;
  logic [RW-1:0] rst_cnt;
  logic [NUM_HARTS-1:0][XLEN-2:0] tn, tn_new;
  logic [NUM_HARTS-1:0] hd_n, hp_n, first;
  logic all_done, tmo, relaunch;
  logic [FH_W-1:0] fh_n;
  logic [XLEN-2:0] tn_n;
  // first marks harts whose ecall is recorded this cycle; later ecalls never overwrite
  always_comb begin
    first = is_ecall & ~hart_done;
    hd_n = hart_done | is_ecall;
    hp_n = hart_pass;
    tn_new = tn;
    fh_n = '0;
    tn_n = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      hp_n[h] = first[h] ? (gp_value[h*XLEN +: XLEN] == PASS_VALUE) : hart_pass[h];
      tn_new[h] = first[h] ? gp_value[h*XLEN+1 +: XLEN-1] : tn[h];
    end
    for (int h = NUM_HARTS - 1; h >= 0; h--) begin
      fh_n = (hd_n[h] && !hp_n[h]) ? FH_W'(h) : fh_n;
      tn_n = (hd_n[h] && !hp_n[h]) ? tn_new[h] : tn_n;
    end
    all_done = &hd_n;
    tmo = run_cycles == CNT_W'(TIMEOUT_CYCLES - 1);
    relaunch = (abort && state != IDLE) || (start && (state == IDLE || state == DONE));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rst_cnt <= '0;
      tn <= '0;
      core_rst_n <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      done_pulse <= 1'b0;
      pass <= 1'b0;
      timeout <= 1'b0;
      hart_done <= '0;
      hart_pass <= '0;
      fail_hart <= '0;
      fail_testnum <= '0;
      run_cycles <= '0;
    end else begin
      done_pulse <= 1'b0;
      if (relaunch) begin
        state <= abort ? IDLE : RESET;
        busy <= !abort;
        rst_cnt <= RW'(RST_CYCLES - 1);
        run_cycles <= abort ? run_cycles : '0;
        tn <= '0;
        core_rst_n <= 1'b0;
        done <= 1'b0;
        pass <= 1'b0;
        timeout <= 1'b0;
        hart_done <= '0;
        hart_pass <= '0;
        fail_hart <= '0;
        fail_testnum <= '0;
      end else if (state == RESET) begin
        state <= (rst_cnt == '0) ? RUN : RESET;
        core_rst_n <= rst_cnt == '0;
        rst_cnt <= (rst_cnt == '0) ? rst_cnt : rst_cnt - 1'b1;
      end else if (state == RUN) begin
        hart_done <= hd_n;
        hart_pass <= hp_n;
        tn <= tn_new;
        if (all_done || tmo) begin
          state <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
          done_pulse <= 1'b1;
          timeout <= !all_done;
          pass <= all_done && (&hp_n);
          fail_hart <= fh_n;
          fail_testnum <= tn_n;
        end else begin
          run_cycles <= run_cycles + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_rv32i_test_ctrl.sv
// tb_rv32i_test_ctrl: scoreboard bench for a 1-hart and a 4-hart (short timeout) controller.
module tb_rv32i_test_ctrl;
  typedef struct packed {
    logic p, t;
    logic [3:0] hd, hp;
    logic [1:0] fh;
    logic [30:0] tn;
    logic [12:0] rc;
  } exp_t;
  logic clk = 0, rst_n = 0;
  logic start1 = 0, abort1 = 0, start4 = 0, abort4 = 0;
  logic [0:0] ec1 = 0;
  logic [3:0] ec4 = 0;
  logic [31:0] gp1 = 0;
  logic [127:0] gp4 = 0;
  logic core1, busy1, done1, dp1, pass1, to1, core4, busy4, done4, dp4, pass4, to4;
  logic [0:0] hd1, hp1, fh1;
  logic [3:0] hd4, hp4;
  logic [1:0] fh4;
  logic [30:0] tn1, tn4;
  logic [12:0] rc1;
  logic [6:0] rc4;
  int checks = 0, errors = 0, cur = 0;
  exp_t q1[$], q4[$];

  always #5 clk = ~clk;

  rv32i_test_ctrl u1 (.clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .is_ecall(ec1),
    .gp_value(gp1), .core_rst_n(core1), .busy(busy1), .done(done1), .done_pulse(dp1), .pass(pass1),
    .timeout(to1), .hart_done(hd1), .hart_pass(hp1), .fail_hart(fh1), .fail_testnum(tn1), .run_cycles(rc1));
  rv32i_test_ctrl #(.NUM_HARTS(4), .TIMEOUT_CYCLES(100)) u4 (.clk(clk), .rst_n(rst_n), .start(start4),
    .abort(abort4), .is_ecall(ec4), .gp_value(gp4), .core_rst_n(core4), .busy(busy4), .done(done4),
    .done_pulse(dp4), .pass(pass4), .timeout(to4), .hart_done(hd4), .hart_pass(hp4), .fail_hart(fh4),
    .fail_testnum(tn4), .run_cycles(rc4));

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  function automatic exp_t mk(logic p, logic t, logic [3:0] hd, logic [3:0] hp, logic [1:0] fh,
                              logic [30:0] tn, logic [12:0] rc);
    return '{p, t, hd, hp, fh, tn, rc};
  endfunction

  task automatic cmp(input string nm, input exp_t a, input exp_t e);
    chk({nm, "_pass"}, a.p, e.p);
    chk({nm, "_timeout"}, a.t, e.t);
    chk({nm, "_hart_done"}, a.hd, e.hd);
    chk({nm, "_hart_pass"}, a.hp, e.hp);
    chk({nm, "_fail_hart"}, a.fh, e.fh);
    chk({nm, "_fail_testnum"}, a.tn, e.tn);
    chk({nm, "_run_cycles"}, a.rc, e.rc);
  endtask

  // monitors: compare every done_pulse against the next queued expectation
  initial forever begin
    @(negedge clk);
    if (dp1) begin
      chk("u1_done_with_pulse", done1, 1);
      if (q1.size() == 0) chk("u1_unexpected_done", 1, 0);
      else cmp("u1", mk(pass1, to1, {3'b0, hd1}, {3'b0, hp1}, {1'b0, fh1}, tn1, rc1), q1.pop_front());
    end
  end
  initial forever begin
    @(negedge clk);
    if (dp4) begin
      chk("u4_done_with_pulse", done4, 1);
      if (q4.size() == 0) chk("u4_unexpected_done", 1, 0);
      else cmp("u4", mk(pass4, to4, hd4, hp4, fh4, tn4, {6'b0, rc4}), q4.pop_front());
    end
  end

  task automatic launch(input bit four);
    @(negedge clk);
    if (four) start4 = 1; else start1 = 1;
    @(negedge clk);
    start1 = 0;
    start4 = 0;
    chk("core_rst_low_first", four ? core4 : core1, 0);
    chk("busy_in_reset", four ? busy4 : busy1, 1);
    repeat (9) @(negedge clk);
    chk("core_rst_low_last", four ? core4 : core1, 0);
    @(negedge clk);
    chk("core_rst_high_run", four ? core4 : core1, 1);
    cur = 0;
  endtask

  task automatic to_cycle(input int k);
    repeat (k - cur) @(negedge clk);
    cur = k;
  endtask

  task automatic ecall1(input int k, input logic [31:0] g);
    to_cycle(k);
    ec1 = 1;
    gp1 = g;
    @(negedge clk);
    ec1 = 0;
    cur++;
  endtask

  task automatic ecall4(input int k, input logic [3:0] m, input logic [127:0] g);
    to_cycle(k);
    ec4 = m;
    gp4 = g;
    @(negedge clk);
    ec4 = 0;
    cur++;
  endtask

  task automatic wait_done(input bit four, input int budget);
    int n = 0;
    while (!(four ? done4 : done1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_within_budget", four ? done4 : done1, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_core_rst_n", core1, 0);
    chk("rst_busy_done", {busy1, done1, dp1, pass1, to1, busy4, done4}, 0);
    chk("rst_results", {hd1, hp1, fh1, tn1, rc1, hd4, fh4, rc4}, 0);
    @(negedge clk);
    rst_n = 1;
    // 1 hart: pass at RUN cycle 37
    q1.push_back(mk(1, 0, 4'b0001, 4'b0001, 0, 0, 37));
    launch(0);
    ecall1(37, 32'd1);
    wait_done(0, 10);
    @(negedge clk);
    chk("done_pulse_one_cycle", dp1, 0);
    chk("done_holds", done1, 1);
    chk("core_runs_in_done", core1, 1);
    // 1 hart: fail with TESTNUM 5
    q1.push_back(mk(0, 0, 4'b0001, 4'b0000, 0, 5, 5));
    launch(0);
    ecall1(5, 32'h0000000B);
    wait_done(0, 10);
    // 1 hart: timeout, with an ignored start while busy
    q1.push_back(mk(0, 1, 0, 0, 0, 0, 4999));
    launch(0);
    to_cycle(100);
    start1 = 1;
    @(negedge clk);
    start1 = 0;
    cur++;
    to_cycle(4998);
    chk("not_done_before_budget", done1, 0);
    wait_done(0, 10);
    // 4 harts: staggered ecalls, hart 2 fails, repeat ecall on hart 0 ignored
    q4.push_back(mk(0, 0, 4'b1111, 4'b1011, 2, 3, 40));
    launch(1);
    ecall4(10, 4'b0001, {4{32'd1}});
    ecall4(15, 4'b0001, {4{32'd9}});
    ecall4(20, 4'b0010, {4{32'd1}});
    ecall4(30, 4'b0100, {4{32'd7}});
    chk("hart0_pass_sticks", hp4[0], 1);
    ecall4(40, 4'b1000, {4{32'd1}});
    wait_done(1, 10);
    // 4 harts: last ecall on the timeout cycle wins
    q4.push_back(mk(1, 0, 4'b1111, 4'b1111, 0, 0, 99));
    launch(1);
    ecall4(5, 4'b0001, {4{32'd1}});
    ecall4(6, 4'b0100, {4{32'd1}});
    ecall4(7, 4'b1000, {4{32'd1}});
    ecall4(99, 4'b0010, {4{32'd1}});
    wait_done(1, 10);
    // 4 harts: simultaneous ecalls, lowest failing index reported
    q4.push_back(mk(0, 0, 4'b1111, 4'b1001, 1, 2, 8));
    launch(1);
    ecall4(8, 4'b1111, {32'd1, 32'd3, 32'd5, 32'd1});
    wait_done(1, 10);
    // 4 harts: timeout with one failed hart recorded
    q4.push_back(mk(0, 1, 4'b1000, 4'b0000, 3, 31'h10, 99));
    launch(1);
    ecall4(2, 4'b1000, {4{32'h21}});
    wait_done(1, 200);
    // abort mid-RUN with a same-cycle start
    launch(1);
    ecall4(10, 4'b0010, {4{32'd1}});
    chk("hart1_done_before_abort", hd4, 4'b0010);
    to_cycle(50);
    abort4 = 1;
    start4 = 1;
    @(negedge clk);
    abort4 = 0;
    start4 = 0;
    chk("abort_idle", {busy4, done4, dp4}, 0);
    chk("abort_core_rst_n", core4, 0);
    chk("abort_clears_hart_done", {hd4, hp4}, 0);
    chk("abort_holds_run_cycles", rc4, 50);
    repeat (3) @(negedge clk);
    chk("start_with_abort_ignored", busy4, 0);
    q4.push_back(mk(1, 0, 4'b1111, 4'b1111, 0, 0, 3));
    launch(1);
    ecall4(3, 4'b1111, {4{32'd1}});
    wait_done(1, 10);
    // async reset mid-RESET
    @(negedge clk);
    start1 = 1;
    @(negedge clk);
    start1 = 0;
    repeat (2) @(negedge clk);
    chk("busy_before_async_rst", busy1, 1);
    #2 rst_n = 0;
    #1;
    chk("async_rst_busy", busy1, 0);
    chk("async_rst_core", core1, 0);
    #1 rst_n = 1;
    repeat (15) @(negedge clk);
    chk("idle_after_async_rst", {busy1, done1, core1}, 0);
    chk("run_cycles_after_rst", rc1, 0);
    chk("u1_queue_drained", q1.size(), 0);
    chk("u4_queue_drained", q4.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
